// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves one branch or jump at a time from the D stage.
// It waits for forwarded operands, drives an external comparator for
// conditional branches, and issues a one-cycle redirect with the target.
// It also keeps saturating counts of resolved and taken branches.
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic [31:0]      pc_d,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    output logic [7:0]       cmp_op,
    output logic [31:0]      cmp_in1,
    output logic [31:0]      cmp_in2,
    input  logic             cmp_out,
    output logic             stall_d,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, EVAL, REDIR} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t      state;
    logic [2:0]  type_q;
    logic [31:0] pc_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [15:0] imm_q;
    logic [25:0] idx_q;
    logic        taken;

    logic [2:0]  cur_type;
    logic        active;
    logic        ready;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jump_target;

    // beq/bne read rs and rt, j/jal read nothing, everything else reads rs only.
    function automatic logic operands_ready(input logic [2:0] t,
                                            input logic rs_rdy,
                                            input logic rt_rdy);
        return ((t == 3'd6) || rs_rdy) && ((t > 3'd1) || rt_rdy);
    endfunction

    function automatic logic is_jump(input logic [2:0] t);
        return t >= 3'd6;
    endfunction

    // In IDLE the new instruction's type decides readiness; in WAIT the latched one.
    assign cur_type    = (state == IDLE) ? br_type : type_q;
    assign active      = ((state == IDLE) && br_valid) || (state == WAIT);
    assign ready       = operands_ready(cur_type, rs_ready, rt_ready);
    assign pc_plus4    = pc_q + 32'd4;
    assign br_target   = pc_plus4 + {{14{imm_q[15]}}, imm_q, 2'b00};
    assign jump_target = {pc_plus4[31:28], idx_q, 2'b00};

    // Branch FSM: capture the instruction, latch operands once final, resolve, count.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see pre-edge values,
        // regardless of statement order inside the block.
        if (reset) begin
            state     <= IDLE;
            type_q    <= '0;
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            idx_q     <= '0;
            taken     <= 1'b0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if ((state == IDLE) && br_valid) begin
                        type_q <= br_type;
                        pc_q   <= pc_d;
                        imm_q  <= imm16;
                        idx_q  <= instr_index;
                        taken  <= 1'b0;
                    end
                    if (active) begin
                        if (ready) begin
                            rs_q <= rs_val;
                            rt_q <= rt_val;
                            if (is_jump(cur_type)) begin
                                taken <= 1'b1;
                                state <= REDIR;
                            end else begin
                                state <= EVAL;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                EVAL: begin
                    taken <= cmp_out;
                    state <= REDIR;
                end
                REDIR: begin
                    if (br_cnt != '1)
                        br_cnt <= br_cnt + CNT_ONE;
                    if (taken && (taken_cnt != '1))
                        taken_cnt <= taken_cnt + CNT_ONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state and latched fields.
    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        cmp_op      = '0;
        cmp_in1     = '0;
        cmp_in2     = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall_d     = 1'b0;
        case (state)
            IDLE: stall_d = br_valid;
            WAIT: stall_d = 1'b1;
            EVAL: begin
                stall_d = 1'b1;
                cmp_op  = {5'd0, type_q} + 8'd1;
                cmp_in1 = rs_q;
                cmp_in2 = (type_q <= 3'd1) ? rt_q : 32'h0;
            end
            REDIR: begin
                redirect = taken;
                if (taken) begin
                    case (type_q)
                        3'd6:    redirect_pc = jump_target;
                        3'd7:    redirect_pc = rs_q;
                        default: redirect_pc = br_target;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the branch and taken counters.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port br_valid  input  1  branch/jump instruction present in D stage.
REQ-005 The block SHALL have port br_type  input  3  instruction class: 0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez, 6 j/jal, 7 jr.
REQ-006 The block SHALL have ports rs_ready and rt_ready  input  1 each  forwarded operand is final.
REQ-007 The block SHALL have ports rs_val and rt_val  input  32 each  forwarded operand values.
REQ-008 The block SHALL have ports pc_d  input  32, imm16  input  16 and instr_index  input  26  branch PC and instruction fields.
REQ-009 The block SHALL have ports cmp_op  output  8, cmp_in1  output  32 and cmp_in2  output  32  drive to the comparator.
REQ-010 The block SHALL have port cmp_out  input  1  comparator result, same cycle.
REQ-011 The block SHALL have port stall_d  output  1  hold F/D stages.
REQ-012 The block SHALL have port redirect  output  1  one-cycle pulse: load redirect_pc into PC.
REQ-013 The block SHALL have port redirect_pc  output  32  jump/branch target.
REQ-014 The block SHALL have ports br_cnt and taken_cnt  output  CNT_W each  resolved and taken counters.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, WAIT, EVAL and REDIR.
REQ-016 Operand need: beq/bne need rs and rt; blez/bgtz/bltz/bgez/jr need rs only; j/jal need none; "ready" means every needed ready bit is 1.
REQ-017 IDLE with br_valid=1 SHALL latch br_type, pc_d, imm16, instr_index; go EVAL if ready and type is 0-5, REDIR if ready and type is 6/7, else WAIT.
REQ-018 Operands SHALL be latched in the same cycle readiness is detected, in IDLE or WAIT; WAIT re-checks every cycle, indefinitely.
REQ-019 WAIT→EVAL or WAIT→REDIR SHALL follow the type rule of REQ-017.
REQ-020 EVAL SHALL drive cmp_op from latched type: EQ 8'h01, NE 8'h02, LEZ 8'h03, GTZ 8'h04, LTZ 8'h05, GEZ 8'h06.
REQ-021 In EVAL, cmp_in1 SHALL be latched rs and cmp_in2 latched rt (beq/bne) or 32'h0 (single-operand).
REQ-022 EVAL SHALL register cmp_out into taken; EVAL→REDIR unconditionally.
REQ-023 Outside EVAL, cmp_op, cmp_in1 and cmp_in2 SHALL be 0.
REQ-024 j/jal/jr SHALL set taken=1 without using the comparator.
REQ-025 Targets: types 0-5 pc+4+(sign_ext(imm16)<<2); j/jal {(pc+4)[31:28], instr_index, 2'b00}; jr latched rs; all arithmetic is mod 2^32, wrap allowed.
REQ-026 REDIR SHALL assert redirect=taken for exactly one cycle, present redirect_pc (valid only with redirect) and go IDLE.
REQ-027 stall_d SHALL be 1 when (IDLE and br_valid) or WAIT or EVAL, and 0 in REDIR and in IDLE without br_valid.
REQ-028 br_valid in WAIT/EVAL/REDIR SHALL be ignored; there is one branch in flight.
REQ-029 Minimum resolution is 3 cycles for conditional branches (IDLE, EVAL, REDIR) and 2 cycles for ready jumps.
REQ-030 There is no flush output; the instruction after the branch is a delay slot and is always executed.
REQ-031 br_cnt SHALL increment on every REDIR cycle and taken_cnt on REDIR with taken=1; both saturate at all-ones.

Reset
REQ-032 When reset=1 at a clock edge, state SHALL go to IDLE, all latches, taken and counters to 0, and all outputs to 0 the following cycle.
REQ-033 Reset in any state SHALL abandon the in-flight branch with no redirect, and reset has priority over all other inputs.

Verification
REQ-034 beq, rs=rt=5, both ready, pc_d=0x3000, imm16=0x0004 -> stall 2 cycles, redirect=1 with redirect_pc=0x3014, br_cnt=1, taken_cnt=1.
REQ-035 bne, rs=rt=7, rt_ready low for 3 cycles -> WAIT 3 cycles, stall_d high 5 cycles, redirect stays 0, br_cnt=1, taken_cnt=0.
REQ-036 bltz, rs=0x80000000, pc_d=0x3000, imm16=0xFFFF -> cmp_op=0x05, cmp_in2=0, redirect_pc=0x3000.
REQ-037 jal, pc_d=0x3FFC, instr_index=0x0000C00 -> EVAL skipped, redirect after 1 stall cycle, redirect_pc=0x00003000.
REQ-038 jr with rs_ready low, then reset asserted in WAIT -> no redirect, counters 0, next-cycle outputs 0; a following beq resolves normally.
REQ-039 CNT_W=2, 5 taken branches -> br_cnt=taken_cnt=3 (saturated).
